// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter sharing one registered ready/valid output slot among N requesters.
// Define STREAM_RR_ARBITER_LOCK_EN to add in_last/out_last and lock the grant across multi-beat bursts.
module stream_rr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 32,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
`ifdef STREAM_RR_ARBITER_LOCK_EN
  input  logic [N-1:0]         in_last,
`endif
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_W-1:0]      out_id,
`ifdef STREAM_RR_ARBITER_LOCK_EN
  output logic                 out_last,
`endif
  input  logic                 out_ready
);

  logic [WIDTH-1:0] data_arr [N];
  logic [N-1:0]     eligible;
  logic [N-1:0]     upper_mask;
  logic [N-1:0]     upper_eligible;
  logic [N-1:0]     pick;
  logic [ID_W-1:0]  grant;
  logic [ID_W-1:0]  ptr_next;
  logic             any_eligible;
  logic             free;

  logic [ID_W-1:0]  ptr_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [ID_W-1:0]  out_id_reg;
`ifdef STREAM_RR_ARBITER_LOCK_EN
  logic             lock_reg;
  logic [ID_W-1:0]  lock_id_reg;
  logic             out_last_reg;
`endif

  assign free = !out_valid_reg || out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
`ifdef STREAM_RR_ARBITER_LOCK_EN
      // A held lock masks every requester except the burst owner, idle or not.
      assign eligible[gi] = in_valid[gi] && (!lock_reg || (lock_id_reg == ID_W'(gi)));
`else
      assign eligible[gi] = in_valid[gi];
`endif
      assign upper_mask[gi] = (ID_W'(gi) >= ptr_reg);
      assign in_ready[gi]   = !reset && free && any_eligible && (grant == ID_W'(gi));
    end
  endgenerate

  // Rotating priority: lowest eligible index at or above ptr wins, else wrap to lowest overall.
  assign upper_eligible = eligible & upper_mask;
  assign pick           = (|upper_eligible) ? upper_eligible : eligible;
  assign any_eligible   = |eligible;

  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick[i]) begin
        grant = ID_W'(i);
      end
    end
  end

  assign ptr_next = (grant == ID_W'(N - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      ptr_reg       <= '0;
`ifdef STREAM_RR_ARBITER_LOCK_EN
      lock_reg      <= 1'b0;
      lock_id_reg   <= '0;
      out_last_reg  <= 1'b0;
`endif
    end else if (free) begin
      if (any_eligible) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= data_arr[grant];
        out_id_reg    <= grant;
`ifdef STREAM_RR_ARBITER_LOCK_EN
        out_last_reg  <= in_last[grant];
        if (!in_last[grant]) begin
          lock_reg    <= 1'b1;
          lock_id_reg <= grant;
        end else begin
          lock_reg    <= 1'b0;
          ptr_reg     <= ptr_next;
        end
`else
        ptr_reg       <= ptr_next;
`endif
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;
`ifdef STREAM_RR_ARBITER_LOCK_EN
  assign out_last  = out_last_reg;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed and randomized checks of stream_rr_arbiter against a queue-free
// behavioural model of the round-robin rules (lock tests only when STREAM_RR_ARBITER_LOCK_EN is set).
module tb_stream_rr_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [ID_W-1:0]    out_id;
  logic               out_ready;
`ifdef STREAM_RR_ARBITER_LOCK_EN
  logic [N-1:0]       in_last;
  logic               out_last;
`endif

  stream_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef STREAM_RR_ARBITER_LOCK_EN
    .in_last  (in_last),
`endif
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
`ifdef STREAM_RR_ARBITER_LOCK_EN
    .out_last (out_last),
`endif
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  int               m_ptr;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  bit               m_lock;
  int               m_lock_id;
  bit               m_last;
  logic [N-1:0]     last_acc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_id      = 0;
    m_lock    = 1'b0;
    m_lock_id = 0;
    m_last    = 1'b0;
  endtask

  // Scan requesters in order ptr, ptr+1, ... (mod N); -1 when nobody is eligible.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (in_valid[i] && (!m_lock || i == m_lock_id)) return i;
    end
    return -1;
  endfunction

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    in_data[i*WIDTH +: WIDTH] = v;
  endtask

  // One clock: check combinational ready, step the model at the edge, check registered outputs.
  task automatic cycle();
    bit           free;
    int           g;
    logic [N-1:0] exp_rdy;
    #1;
    free    = !m_valid || out_ready;
    g       = model_grant();
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("in_ready", in_ready, exp_rdy);
    last_acc = exp_rdy;
    @(posedge clock);
    if (free) begin
      if (g >= 0) begin
        m_valid = 1'b1;
        m_data  = in_data[g*WIDTH +: WIDTH];
        m_id    = g;
`ifdef STREAM_RR_ARBITER_LOCK_EN
        m_last = in_last[g];
        if (!in_last[g]) begin
          m_lock    = 1'b1;
          m_lock_id = g;
        end else begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % N;
        end
`else
        m_ptr = (g + 1) % N;
`endif
        $display("beat id=%0d data=%08h", g, m_data);
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_eq("out_valid", out_valid, m_valid);
    check_eq("out_data", out_data, m_data);
    check_eq("out_id", out_id, m_id);
`ifdef STREAM_RR_ARBITER_LOCK_EN
    check_eq("out_last", out_last, m_last);
`endif
  endtask

  initial begin
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    last_acc  = '0;
`ifdef STREAM_RR_ARBITER_LOCK_EN
    in_last   = '1;
`endif
    model_reset();

    // Reset then idle
    #1 reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_id", out_id, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    cycle();
    cycle();
    check_eq("idle_in_ready", in_ready, 0);

    // Round-robin with all requesters valid
    for (int i = 0; i < N; i++) set_data(i, WIDTH'(32'hA0 + i));
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check_eq("rr_id", out_id, k % N);
      check_eq("rr_data", out_data, 32'hA0 + (k % N));
    end
    cycle();
    check_eq("rr_id5", out_id, 1);

    // Backpressure holds the slot
    out_ready = 1'b0;
    repeat (3) begin
      cycle();
      check_eq("bp_data", out_data, 32'hA1);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    cycle();
    check_eq("bp_release_id", out_id, 2);
    check_eq("bp_release_data", out_data, 32'hA2);

    // Pointer skip and wrap (ptr is 3 here)
    in_valid = 4'b0010;
    cycle();
    check_eq("skip_id", out_id, 1);
    in_valid = 4'b0100;
    cycle();
    check_eq("skip_id2", out_id, 2);
    in_valid = 4'b1001;
    cycle();
    check_eq("wrap_id", out_id, 3);
    in_valid = 4'b0011;
    cycle();
    check_eq("wrap_next_id", out_id, 0);

    // Asynchronous reset mid-transfer
    in_valid = 4'b0100;
    cycle();
    check_eq("pre_rst_valid", out_valid, 1);
    out_ready = 1'b0;
    in_valid  = 4'b0000;
    #3 reset = 1'b1;
    #1;
    check_eq("async_rst_valid", out_valid, 0);
    check_eq("async_rst_id", out_id, 0);
    check_eq("async_rst_ready", in_ready, 0);
    model_reset();
    #1 reset = 1'b0;
    in_valid  = 4'b1010;
    out_ready = 1'b1;
    cycle();
    check_eq("post_rst_id", out_id, 1);

`ifdef STREAM_RR_ARBITER_LOCK_EN
    // Burst lock: requester 2 sends three beats, requester 0 waits
    in_valid = 4'b0101;
    set_data(0, 32'hC0);
    in_last[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      in_last[2] = (b == 2);
      set_data(2, WIDTH'(32'hB0 + b));
      cycle();
      check_eq("lock_id", out_id, 2);
      if (b < 2) check_eq("lock_ready0", in_ready[0], 0);
    end
    in_valid = 4'b0001;
    cycle();
    check_eq("unlock_id", out_id, 0);
    check_eq("unlock_data", out_data, 32'hC0);
`endif

    // Randomized traffic, requests held until accepted
    repeat (400) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] || last_acc[i]) begin
          in_valid[i] = ($urandom_range(0, 1) == 1);
          set_data(i, WIDTH'($urandom));
`ifdef STREAM_RR_ARBITER_LOCK_EN
          in_last[i] = ($urandom_range(0, 2) != 0);
`endif
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #3 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one ready/valid stream channel among N upstream requesters, with round-robin fairness.
- Sits in front of a skid-buffer stage, e.g. multiple fetch/LSU sources feeding one bus-request skid buffer.
- Holds each accepted beat in a registered output slot, tagged with the source index.
- Sustains one beat per cycle when downstream is always ready.

Parameters:
- N, 4, number of requesters (min 1).
- WIDTH, 32, payload width per requester.
- ID_W, (N > 1 ? $clog2(N) : 1), width of the source-index tag (derived; do not override).

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-requester valid.
- in_data  input  N*WIDTH  packed payloads; requester i at [i*WIDTH +: WIDTH].
- in_ready  output  N  per-requester ready; combinational; at most one bit set.
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered payload.
- out_id  output  ID_W  registered index of the source of out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_id=0, rr pointer ptr=0, burst lock cleared. While reset is high, in_ready=0.
- Reset asserted mid-transfer discards the held beat. No beat is duplicated or emitted after reset.
- Output slot free condition: free = !out_valid || out_ready.
- Arbitration (combinational):
  - g = first index i, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1, with in_valid[i]=1.
  - in_ready[g] = free && any(in_valid). All other in_ready bits = 0.
  - in_ready does not depend on in_valid of the granted requester beyond selection. No combinational path from in_data.
- Transfer: handshake on requester g when in_valid[g] && in_ready[g]. At that clock edge:
  - out_data <= in_data[g]
  - out_id <= g
  - out_valid <= 1
  - ptr <= (g == N-1) ? 0 : g+1
- Free with no in_valid: out_valid <= 0; out_data and out_id hold; ptr holds.
- Not free (out_valid=1, out_ready=0): out_valid, out_data and out_id are held stable; ptr holds; in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 beat/cycle when out_ready=1. A simultaneous output drain and input load is legal and required.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,...,N-1,0,... Worst-case wait is N-1 grants.
- N=1: ID_W=1, out_id always 0, ptr stays 0.
- No internal buffering beyond the single output register. Upstream must hold in_data/in_valid until it sees ready.

Optional Feature:
- Macro: STREAM_RR_ARBITER_LOCK_EN.
- Defined:
  - Adds input in_last, width N (per-requester last-beat flag), and output out_last, width 1 (registered with out_data).
  - When a beat from g is accepted with in_last[g]=0, the lock sets with lock_id=g and ptr is not advanced.
  - While locked, only requester lock_id is eligible. in_ready bits of all other requesters are 0 even if lock_id is idle.
  - The lock clears on acceptance of a beat from lock_id with in_last=1; ptr then advances to lock_id+1.
  - Reset clears the lock.
- Undefined: no in_last/out_last ports. Every beat is arbitrated independently, as above.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all in_valid=0 -> out_valid=0, out_id=0, in_ready=0000; after release, in_ready remains 0000.
- Round-robin: N=4, in_valid=1111, data i=0xA0+i, out_ready=1 -> out_id sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0..0xA3,0xA0, one beat per cycle.
- Backpressure: slot holds 0xA1 from id 1, out_ready=0 for 3 cycles -> out_valid=1, out_data=0xA1 stable, in_ready=0000; out_ready=1 -> next beat (id 2) loaded the same edge.
- Pointer skip/wrap: ptr=3, in_valid=0010 -> grant 1, ptr becomes 2; then ptr=3, in_valid=1001 -> grant 3, ptr wraps to 0.
- Reset mid-operation: out_valid=1, out_ready=0, reset pulse asynchronously between edges -> out_valid=0 immediately, ptr=0; first post-reset grant to lowest valid index.
- Lock (macro defined): requester 2 sends 3 beats with last on the 3rd, requester 0 valid throughout -> out_id=2,2,2, then 0; in_ready[0]=0 until the last beat is accepted.
